// File: rtl/dram_cycle_sequencer.sv
// Clocked SRAM sequencer behind the C64 DRAM socket: synchronises host strobes, latches row/column,
// runs one timed SRAM access per CAS and idles through CBR refresh. Optional macro: PAGE_MODE_EN.
module dram_cycle_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int ACC_CYCLES  = 3,
  parameter int BANK_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            maddress,
  input  logic                  _ras,
  input  logic                  _cas,
  input  logic                  _we,
  input  logic [BANK_W-1:0]     bank,
  input  logic [7:0]            bdata_in,
  output logic [16+BANK_W-1:0]  baddress,
  output logic                  _ce_ram,
  output logic                  _we_ram,
  output logic [7:0]            rdata,
  output logic                  data_oe,
  output logic                  bdata_oe,
  output logic                  refresh,
  output logic                  busy
);

  localparam int SYNC_W = 11;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACC_CYCLES - 1);
  localparam logic [CNT_W-1:0] WE_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] WE_LAST  = CNT_W'(ACC_CYCLES - 2);

  typedef enum logic [2:0] {IDLE, ROW, ACCESS, HOLD, CAS_UP, REFRESH} state_t;

  logic [SYNC_W-1:0] sync_p [SYNC_STAGES];
  logic              s_ras, s_cas, s_we;
  logic [7:0]        s_addr;
  logic              prev_ras, prev_cas;
  logic              ras_fall, ras_rise, cas_fall, cas_rise;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              wr, wr_nx;
  logic              lat_row, lat_col, lat_rd, refresh_nx;

  // Stage boundary: pin synchroniser, strobes idle high and address zero out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= {3'b111, 8'h00};
    end else begin
      sync_p[0] <= {_ras, _cas, _we, maddress};
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign {s_ras, s_cas, s_we, s_addr} = sync_p[SYNC_STAGES-1];

  assign ras_fall = (prev_ras != s_ras) && !s_ras;
  assign ras_rise = (prev_ras != s_ras) &&  s_ras;
  assign cas_fall = (prev_cas != s_cas) && !s_cas;
  assign cas_rise = (prev_cas != s_cas) &&  s_cas;

  // Stage boundary: edge history and FSM state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_ras <= 1'b1;
      prev_cas <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      wr       <= 1'b0;
    end else begin
      prev_ras <= s_ras;
      prev_cas <= s_cas;
      state    <= state_nx;
      cnt      <= cnt_nx;
      wr       <= wr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    wr_nx      = wr;
    lat_row    = 1'b0;
    lat_col    = 1'b0;
    lat_rd     = 1'b0;
    refresh_nx = 1'b0;
    if (ras_rise) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ras_fall) begin
            if (s_cas) begin
              lat_row  = 1'b1;
              state_nx = ROW;
            end else begin
              refresh_nx = 1'b1;
              state_nx   = REFRESH;
            end
          end
        end
        ROW: begin
          if (cas_fall) begin
            lat_col  = 1'b1;
            wr_nx    = !s_we;
            cnt_nx   = '0;
            state_nx = ACCESS;
          end
        end
        ACCESS: begin
          // The access always runs to completion even if CAS already went away
          if (cnt == ACC_LAST) begin
            lat_rd   = !wr;
            state_nx = s_cas ? CAS_UP : HOLD;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (cas_rise) state_nx = CAS_UP;
        end
        CAS_UP: begin
`ifdef PAGE_MODE_EN
          if (!s_ras) state_nx = ROW;
`else
          state_nx = CAS_UP;
`endif
        end
        REFRESH: state_nx = REFRESH;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Stage boundary: outputs registered from next-state so SRAM strobes are glitch-free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      _ce_ram  <= 1'b1;
      _we_ram  <= 1'b1;
      bdata_oe <= 1'b0;
      data_oe  <= 1'b0;
      refresh  <= 1'b0;
      busy     <= 1'b0;
      baddress <= '0;
      rdata    <= '0;
    end else begin
      _ce_ram  <= (state_nx != ACCESS);
      _we_ram  <= !((state_nx == ACCESS) && wr_nx && (cnt_nx >= WE_FIRST) && (cnt_nx <= WE_LAST));
      bdata_oe <= (state_nx == ACCESS) && wr_nx;
      data_oe  <= (state_nx == HOLD) && !wr_nx;
      refresh  <= refresh_nx;
      busy     <= (state_nx != IDLE);
      if (lat_row) baddress <= {bank, baddress[15:8], s_addr};
      if (lat_col) baddress <= {bank, s_addr, baddress[7:0]};
      if (lat_rd)  rdata    <= bdata_in;
    end
  end

endmodule

// File: tb/tb_dram_cycle_sequencer.sv
// Directed bench for dram_cycle_sequencer: read, write, CBR refresh, page mode, abort, reset mid-access.
module tb_dram_cycle_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  maddress;
  logic        ras_n, cas_n, we_n;
  logic [4:0]  bank;
  logic [7:0]  bdata_in;
  logic [20:0] baddress;
  logic        ce_ram_n, we_ram_n;
  logic [7:0]  rdata;
  logic        data_oe, bdata_oe, refresh, busy;

  int n_assert = 0;
  int n_fail   = 0;

  int ce_lo = 0, we_lo = 0, ref_cnt = 0, acc_cnt = 0, doe_cnt = 0;
  logic ce_prev = 1'b1;
  int b_ce, b_we, b_ref, b_acc, b_doe;

  dram_cycle_sequencer #(.SYNC_STAGES(2), .ACC_CYCLES(3), .BANK_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .maddress (maddress),
    ._ras     (ras_n),
    ._cas     (cas_n),
    ._we      (we_n),
    .bank     (bank),
    .bdata_in (bdata_in),
    .baddress (baddress),
    ._ce_ram  (ce_ram_n),
    ._we_ram  (we_ram_n),
    .rdata    (rdata),
    .data_oe  (data_oe),
    .bdata_oe (bdata_oe),
    .refresh  (refresh),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!ce_ram_n) ce_lo++;
    if (!we_ram_n) we_lo++;
    if (refresh)   ref_cnt++;
    if (data_oe)   doe_cnt++;
    if (ce_prev && !ce_ram_n) acc_cnt++;
    ce_prev = ce_ram_n;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_ce = ce_lo; b_we = we_lo; b_ref = ref_cnt; b_acc = acc_cnt; b_doe = doe_cnt;
  endtask

  initial begin
    reset = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    maddress = 8'h00; bank = 5'h00; bdata_in = 8'h00;
    tick(3);
    check("rst_ce",       ce_ram_n, 1);
    check("rst_we",       we_ram_n, 1);
    check("rst_doe",      data_oe,  0);
    check("rst_boe",      bdata_oe, 0);
    check("rst_refresh",  refresh,  0);
    check("rst_busy",     busy,     0);
    check("rst_baddress", baddress, 0);
    check("rst_rdata",    rdata,    0);
    reset = 1'b0;
    tick(3);

    // 1. Read: row 0x12, col 0x34, data 0xA5
    snap();
    maddress = 8'h12; ras_n = 1'b0;
    tick(3);
    check("rd_row_busy", busy, 1);
    check("rd_row_addr", baddress, 32'h00012);
    maddress = 8'h34; cas_n = 1'b0; bdata_in = 8'hA5;
    tick(3);
    check("rd_ce_c0",   ce_ram_n, 0);
    check("rd_addr",    baddress, 32'h03412);
    check("rd_boe",     bdata_oe, 0);
    check("rd_doe_acc", data_oe,  0);
    tick(2);
    check("rd_ce_c2",   ce_ram_n, 0);
    tick(1);
    check("rd_ce_end",  ce_ram_n, 1);
    check("rd_doe",     data_oe,  1);
    check("rd_rdata",   rdata,    32'hA5);
    tick(2);
    check("rd_doe_hold", data_oe, 1);
    cas_n = 1'b1;
    tick(2);
    check("rd_doe_cas2", data_oe, 1);
    tick(1);
    check("rd_doe_off",  data_oe, 0);
    check("rd_casup_busy", busy, 1);
    ras_n = 1'b1;
    tick(3);
    check("rd_idle_busy", busy, 0);
    check("rd_addr_keep", baddress, 32'h03412);
    check("rd_ce_count",  ce_lo - b_ce, 3);
    check("rd_we_count",  we_lo - b_we, 0);

    // 2. Write: row 0xFF, col 0x00
    snap();
    maddress = 8'hFF; ras_n = 1'b0;
    tick(3);
    maddress = 8'h00; we_n = 1'b0; cas_n = 1'b0;
    tick(3);
    check("wr_ce_c0",  ce_ram_n, 0);
    check("wr_we_c0",  we_ram_n, 1);
    check("wr_boe_c0", bdata_oe, 1);
    tick(1);
    check("wr_we_c1",  we_ram_n, 0);
    check("wr_boe_c1", bdata_oe, 1);
    tick(1);
    check("wr_we_c2",  we_ram_n, 1);
    check("wr_boe_c2", bdata_oe, 1);
    tick(1);
    check("wr_ce_hold",  ce_ram_n, 1);
    check("wr_boe_hold", bdata_oe, 0);
    check("wr_doe_hold", data_oe,  0);
    check("wr_addr",     baddress, 32'h000FF);
    cas_n = 1'b1; we_n = 1'b1;
    tick(3);
    ras_n = 1'b1;
    tick(3);
    check("wr_ce_count", ce_lo - b_ce, 3);
    check("wr_we_count", we_lo - b_we, 1);
    check("wr_rdata_keep", rdata, 32'hA5);

    // 3. CBR refresh
    snap();
    cas_n = 1'b0;
    tick(2);
    ras_n = 1'b0;
    tick(3);
    check("cbr_refresh", refresh, 1);
    check("cbr_busy",    busy,    1);
    tick(1);
    check("cbr_refresh_off", refresh, 0);
    tick(2);
    cas_n = 1'b1; ras_n = 1'b1;
    tick(2);
    check("cbr_busy_hold", busy, 1);
    tick(1);
    check("cbr_busy_off", busy, 0);
    check("cbr_ref_count", ref_cnt - b_ref, 1);
    check("cbr_ce_count",  ce_lo - b_ce, 0);

    // 4. Page mode: one RAS, three CAS pulses
    snap();
    maddress = 8'h55; ras_n = 1'b0;
    tick(3);
    for (int c = 1; c <= 3; c++) begin
      maddress = 8'(c); cas_n = 1'b0;
      tick(6);
      cas_n = 1'b1;
      tick(4);
    end
    ras_n = 1'b1;
    tick(3);
`ifdef PAGE_MODE_EN
    check("pg_acc_count", acc_cnt - b_acc, 3);
    check("pg_ce_count",  ce_lo - b_ce, 9);
    check("pg_doe_count", doe_cnt - b_doe, 9);
    check("pg_addr",      baddress, 32'h00355);
`else
    check("pg_acc_count", acc_cnt - b_acc, 1);
    check("pg_ce_count",  ce_lo - b_ce, 3);
    check("pg_doe_count", doe_cnt - b_doe, 3);
    check("pg_addr",      baddress, 32'h00155);
`endif
    check("pg_busy_off", busy, 0);

    // 5. Abort: RAS rises during write at counter 1
    snap();
    maddress = 8'h0A; ras_n = 1'b0;
    tick(3);
    maddress = 8'h0B; we_n = 1'b0; cas_n = 1'b0;
    tick(2);
    ras_n = 1'b1;
    tick(1);
    check("ab_ce_c0", ce_ram_n, 0);
    tick(1);
    check("ab_we_c1", we_ram_n, 0);
    tick(1);
    check("ab_ce",   ce_ram_n, 1);
    check("ab_we",   we_ram_n, 1);
    check("ab_boe",  bdata_oe, 0);
    check("ab_busy", busy,     0);
    cas_n = 1'b1; we_n = 1'b1;
    tick(3);
    check("ab_ce_count", ce_lo - b_ce, 2);
    check("ab_we_count", we_lo - b_we, 1);

    // 6. Reset mid-access, then a normal read with a nonzero bank
    maddress = 8'h21; ras_n = 1'b0;
    tick(3);
    maddress = 8'h43; cas_n = 1'b0; bdata_in = 8'h5A;
    tick(4);
    check("rs_pre_ce", ce_ram_n, 0);
    reset = 1'b1;
    #1;
    check("rs_ce",       ce_ram_n, 1);
    check("rs_we",       we_ram_n, 1);
    check("rs_busy",     busy,     0);
    check("rs_baddress", baddress, 0);
    check("rs_rdata",    rdata,    0);
    check("rs_doe",      data_oe,  0);
    check("rs_boe",      bdata_oe, 0);
    ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(3);
    snap();
    bank = 5'h1F; maddress = 8'h66; ras_n = 1'b0;
    tick(3);
    check("rs_row_addr", baddress, 32'h1F0066);
    maddress = 8'h77; cas_n = 1'b0; bdata_in = 8'h3C;
    tick(6);
    check("rs_addr",  baddress, 32'h1F7766);
    check("rs_rdata_new", rdata, 32'h3C);
    check("rs_doe_new",   data_oe, 1);
    cas_n = 1'b1;
    tick(3);
    ras_n = 1'b1;
    tick(3);
    check("rs_ce_count", ce_lo - b_ce, 3);
    check("rs_busy_off", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
